hld_pulse_monitor: RTL
======================

// Module: hld_pulse_monitor
// PURPOSE
//  Receive-side checker for the DLL hold-control pulse (Ctrl_HLD) produced by the hold controller.
//  Synchronises the pulse into the monitor clock domain and measures its high width and period.
//  Compares both against programmed targets and declares hold-lock after LOCK_N good pulses.
//  Flags width/period/timeout errors. Feeds lock status to the FMDLL calibration sequencer.
// PARAMETERS
//  W       8  width of counters, targets and measurements
//  LOCK_N  4  consecutive good measurements needed to lock (>=1)
//  LOSS_N  2  consecutive bad measurements in LOCKED needed to drop lock (>=1)
// PORTS
//  clk          in   1  monitor clock
//  rst_n        in   1  asynchronous active-low reset
//  en           in   1  monitor enable; low = IDLE
//  M            in   1  divider mode of the hold controller; any change restarts acquisition
//  Ctrl_HLD     in   1  hold pulse, asynchronous to clk
//  exp_high     in   W  expected high width, in clk cycles
//  exp_period   in   W  expected rise-to-rise period, in clk cycles
//  tol          in   W  allowed absolute deviation for both checks
//  meas_high    out  W  last measured high width
//  meas_period  out  W  last measured period
//  meas_valid   out  1  1-cycle strobe: new meas_high/meas_period pair checked
//  hld_err      out  1  1-cycle strobe: bad measurement or timeout
//  hld_lock     out  1  lock status (level)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, all counters 0, synchroniser flops 0.
//  Sync: 2-flop synchroniser -> hld_s; hld_d = hld_s delayed 1 cycle.
//   rise = hld_s & ~hld_d; fall = ~hld_s & hld_d.
//  cyc_cnt: counts clk cycles since the last rise; set to 1 on the cycle after a rise.
//   Saturates at 2^W-1.
//   Rise at cycle t0 with next rise at t0+P gives period = P. high = cyc_cnt captured at fall.
//  FSM states:
//   IDLE: en=0. Counters cleared, hld_lock=0. en=1 -> ACQ.
//   ACQ: waits for the first rise (no measurement yet). rise -> MEAS.
//   MEAS: each rise latches period and the pending high value, then evaluates the pair.
//   LOCKED: same evaluation as MEAS; hld_lock=1.
//  Evaluation (MEAS/LOCKED, on the rise strobe): registered, so outputs update 1 cycle after rise.
//   meas_valid pulses 1. good = |period-exp_period|<=tol AND |high-exp_high|<=tol.
//   Differences are computed in W+1 bits, with no wrap.
//   A period with no fall seen (stuck high between rises) is bad.
//  Counter and state updates on each evaluation:
//   MEAS, good: good_cnt++; when good_cnt reaches LOCK_N -> LOCKED, hld_lock=1 in the same cycle as meas_valid.
//   MEAS, bad: good_cnt=0, hld_err pulse.
//   LOCKED, good: bad_cnt=0.
//   LOCKED, bad: hld_err pulse, bad_cnt++; at LOSS_N -> MEAS, hld_lock=0, good_cnt=0.
//  Timeout: cyc_cnt reaching 2^W-1 in MEAS/LOCKED -> hld_err pulse once, hld_lock=0, state ACQ.
//  M change (M registered; M != M_q) -> ACQ, hld_lock=0, good/bad counts 0, no err. Takes priority over evaluation.
//  en=0 in any state -> IDLE next cycle. Takes priority over M change and timeout.
//  Async reset mid-operation: immediate return to reset values. The first rise after release only arms (ACQ).
//  meas_high/meas_period hold their values between strobes.
// TESTING
//  1 Reset: assert rst_n=0 mid-LOCKED -> all outputs 0 immediately. After release, the first rise gives no meas_valid.
//  2 Lock: period 8, high 4, exp 8/4, tol 0, LOCK_N=4 -> meas_valid on rises 2..5.
//    hld_lock rises with the 4th meas_valid; hld_err never asserted.
//  3 Tolerance: tol=1, periods 7/9 and highs 3/5 alternating -> lock achieved.
//    A period of 10 -> hld_err pulse, good_cnt reset.
//  4 Loss: once LOCKED, one bad period 12 -> hld_err, lock held.
//    Two consecutive bad periods -> hld_lock=0, state MEAS.
//  5 Timeout: hold Ctrl_HLD high in LOCKED (W=8) -> single hld_err after 255 cycles from the last rise.
//    Then hld_lock=0 and the next rise only re-arms.
//  6 Mode/enable: toggle M in LOCKED -> hld_lock=0 next cycle, no hld_err.
//    en=0 -> IDLE, no strobes while low.

Source files
------------

// File: rtl/hld_pulse_monitor_if.sv
// Signal bundle between the hold-pulse source/configuration side and the monitor.
// The monitor takes the slave view; whoever drives Ctrl_HLD and the targets takes the master view.
interface hld_pulse_monitor_if #(
    parameter int W = 8
);
    logic         en;
    logic         M;
    logic         Ctrl_HLD;
    logic [W-1:0] exp_high;
    logic [W-1:0] exp_period;
    logic [W-1:0] tol;
    logic [W-1:0] meas_high;
    logic [W-1:0] meas_period;
    logic         meas_valid;
    logic         hld_err;
    logic         hld_lock;

    modport master (
        output en, M, Ctrl_HLD, exp_high, exp_period, tol,
        input  meas_high, meas_period, meas_valid, hld_err, hld_lock
    );

    modport slave (
        input  en, M, Ctrl_HLD, exp_high, exp_period, tol,
        output meas_high, meas_period, meas_valid, hld_err, hld_lock
    );
endinterface

// File: rtl/hld_pulse_monitor.sv
// Receive-side checker for the DLL hold-control pulse: synchronises Ctrl_HLD, measures
// its high width and rise-to-rise period, and tracks hold-lock for the calibration sequencer.
module hld_pulse_monitor #(
    parameter int W      = 8,
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    hld_pulse_monitor_if.slave bus
);
    localparam int GW = $clog2(LOCK_N + 1);
    localparam int BW = $clog2(LOSS_N + 1);
    localparam logic [W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACQ, MEAS, LOCKED} state_t;

    state_t        state, state_nxt;
    logic          sync_p0, hld_s, hld_d, m_q;
    logic          rise, fall, m_chg, timeout, good;
    logic [W-1:0]  cyc_cnt, cyc_cnt_nxt;
    logic [W-1:0]  high_pend, high_pend_nxt;
    logic          fall_seen, fall_seen_nxt;
    logic [GW-1:0] good_cnt, good_cnt_nxt;
    logic [BW-1:0] bad_cnt, bad_cnt_nxt;
    logic [W-1:0]  meas_high, meas_high_nxt;
    logic [W-1:0]  meas_period, meas_period_nxt;
    logic          meas_valid, meas_valid_nxt;
    logic          hld_err, hld_err_nxt;
    logic          hld_lock, hld_lock_nxt;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] x);
        return (x == CNT_MAX) ? x : x + 1'b1;
    endfunction

    // Deviation is formed one bit wider than the operands so it can never wrap.
    function automatic logic within_tol(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] t);
        logic [W:0] ea, eb, d;
        ea = {1'b0, a};
        eb = {1'b0, b};
        d  = (ea >= eb) ? ea - eb : eb - ea;
        return d <= {1'b0, t};
    endfunction

    assign rise    = hld_s & ~hld_d;
    assign fall    = ~hld_s & hld_d;
    assign m_chg   = (bus.M != m_q);
    assign timeout = (cyc_cnt == CNT_MAX);
    assign good    = fall_seen
                   && within_tol(cyc_cnt, bus.exp_period, bus.tol)
                   && within_tol(high_pend, bus.exp_high, bus.tol);

    always_comb begin
        state_nxt       = state;
        cyc_cnt_nxt     = sat_inc(cyc_cnt);
        high_pend_nxt   = high_pend;
        fall_seen_nxt   = fall_seen;
        good_cnt_nxt    = good_cnt;
        bad_cnt_nxt     = bad_cnt;
        meas_high_nxt   = meas_high;
        meas_period_nxt = meas_period;
        meas_valid_nxt  = 1'b0;
        hld_err_nxt     = 1'b0;
        hld_lock_nxt    = hld_lock;

        // A rise restarts the period count; a stuck-high period reports a zero high width.
        if (rise) begin
            cyc_cnt_nxt   = W'(1);
            high_pend_nxt = '0;
            fall_seen_nxt = 1'b0;
        end else if (fall) begin
            high_pend_nxt = cyc_cnt;
            fall_seen_nxt = 1'b1;
        end

        if (!bus.en || state == IDLE) begin
            state_nxt     = bus.en ? ACQ : IDLE;
            cyc_cnt_nxt   = '0;
            high_pend_nxt = '0;
            fall_seen_nxt = 1'b0;
            good_cnt_nxt  = '0;
            bad_cnt_nxt   = '0;
            hld_lock_nxt  = 1'b0;
        end else if (m_chg) begin
            state_nxt    = ACQ;
            good_cnt_nxt = '0;
            bad_cnt_nxt  = '0;
            hld_lock_nxt = 1'b0;
        end else if (timeout && state != ACQ) begin
            state_nxt    = ACQ;
            good_cnt_nxt = '0;
            bad_cnt_nxt  = '0;
            hld_lock_nxt = 1'b0;
            hld_err_nxt  = 1'b1;
        end else if (rise) begin
            if (state == ACQ) begin
                state_nxt = MEAS;
            end else begin
                meas_valid_nxt  = 1'b1;
                meas_period_nxt = cyc_cnt;
                meas_high_nxt   = high_pend;
                if (state == MEAS) begin
                    if (good) begin
                        good_cnt_nxt = good_cnt + 1'b1;
                        if (good_cnt == GW'(LOCK_N - 1)) begin
                            state_nxt    = LOCKED;
                            hld_lock_nxt = 1'b1;
                            bad_cnt_nxt  = '0;
                        end
                    end else begin
                        good_cnt_nxt = '0;
                        hld_err_nxt  = 1'b1;
                    end
                end else if (good) begin
                    bad_cnt_nxt = '0;
                end else begin
                    hld_err_nxt = 1'b1;
                    if (bad_cnt == BW'(LOSS_N - 1)) begin
                        state_nxt    = MEAS;
                        hld_lock_nxt = 1'b0;
                        good_cnt_nxt = '0;
                        bad_cnt_nxt  = '0;
                    end else begin
                        bad_cnt_nxt = bad_cnt + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0     <= 1'b0;
            hld_s       <= 1'b0;
            hld_d       <= 1'b0;
            m_q         <= 1'b0;
            state       <= IDLE;
            cyc_cnt     <= '0;
            high_pend   <= '0;
            fall_seen   <= 1'b0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            meas_high   <= '0;
            meas_period <= '0;
            meas_valid  <= 1'b0;
            hld_err     <= 1'b0;
            hld_lock    <= 1'b0;
        end else begin
            sync_p0     <= bus.Ctrl_HLD;
            hld_s       <= sync_p0;
            hld_d       <= hld_s;
            m_q         <= bus.M;
            state       <= state_nxt;
            cyc_cnt     <= cyc_cnt_nxt;
            high_pend   <= high_pend_nxt;
            fall_seen   <= fall_seen_nxt;
            good_cnt    <= good_cnt_nxt;
            bad_cnt     <= bad_cnt_nxt;
            meas_high   <= meas_high_nxt;
            meas_period <= meas_period_nxt;
            meas_valid  <= meas_valid_nxt;
            hld_err     <= hld_err_nxt;
            hld_lock    <= hld_lock_nxt;
        end
    end

    assign bus.meas_high   = meas_high;
    assign bus.meas_period = meas_period;
    assign bus.meas_valid  = meas_valid;
    assign bus.hld_err     = hld_err;
    assign bus.hld_lock    = hld_lock;
endmodule
